// File: rtl/reg_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_shift_sequencer
// Description : Multi-cycle register-specified shift controller. Shifts Rm in
//               chunks of up to STEP bits per cycle, applying ARM
//               LSL/LSR/ASR/ROR shift-by-register rules for amounts 0..255.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_shift_sequencer #(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  shift_type,
    input  logic [31:0] rm,
    input  logic [7:0]  rs_amt,
    input  logic        c_in,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] c_lsl  = 2'b00;
    localparam logic [1:0] c_lsr  = 2'b01;
    localparam logic [1:0] c_asr  = 2'b10;
    localparam logic [1:0] c_ror  = 2'b11;
    localparam logic [5:0] c_step = 6'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_result;
    logic        r_carry;
    logic [1:0]  r_type;
    logic [5:0]  r_count;
    logic [5:0]  w_count_init;
    logic [5:0]  w_n;
    logic [63:0] w_wide;
    logic [31:0] w_shifted;
    logic        w_shift_carry;

    assign result    = r_result;
    assign carry_out = r_carry;

    // Remaining positions to shift. Amounts beyond 33 (LSL/LSR) or 32 (ASR)
    // give the same result as the clamp, and ROR only cares about the
    // amount modulo 32 (with nonzero multiples of 32 as a full rotation).
    always_comb begin
        w_count_init = 6'd0;
        case (shift_type)
            c_lsl, c_lsr: w_count_init = (rs_amt > 8'd33) ? 6'd33 : rs_amt[5:0];
            c_asr:        w_count_init = (rs_amt > 8'd32) ? 6'd32 : rs_amt[5:0];
            default: begin
                if (rs_amt == 8'd0)
                    w_count_init = 6'd0;
                else if (rs_amt[4:0] == 5'd0)
                    w_count_init = 6'd32;
                else
                    w_count_init = {1'b0, rs_amt[4:0]};
            end
        endcase
    end

    // One chunk of shifting; the 64-bit window keeps the last bit shifted
    // out next to the result so carry needs no special cases.
    always_comb begin
        w_n           = (r_count > c_step) ? c_step : r_count;
        w_wide        = 64'd0;
        w_shifted     = r_result;
        w_shift_carry = r_carry;
        case (r_type)
            c_lsl: begin
                w_wide        = {32'd0, r_result} << w_n;
                w_shifted     = w_wide[31:0];
                w_shift_carry = w_wide[32];
            end
            c_lsr: begin
                w_wide        = {r_result, 32'd0} >> w_n;
                w_shifted     = w_wide[63:32];
                w_shift_carry = w_wide[31];
            end
            c_asr: begin
                w_wide        = 64'($signed({r_result, 32'd0}) >>> w_n);
                w_shifted     = w_wide[63:32];
                w_shift_carry = w_wide[31];
            end
            default: begin
                w_wide        = {r_result, r_result} >> w_n;
                w_shifted     = w_wide[31:0];
                w_shift_carry = w_wide[31];
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state and status decode; start is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next_state = (w_count_init != 6'd0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (r_count == w_n)
                    w_next_state = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand capture on an accepted start, then one chunk per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 32'd0;
            r_carry  <= 1'b0;
            r_type   <= 2'b00;
            r_count  <= 6'd0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_result <= rm;
                r_carry  <= c_in;
                r_type   <= shift_type;
                r_count  <= w_count_init;
            end
        end else if (r_state == S_SHIFT) begin
            r_result <= w_shifted;
            r_carry  <= w_shift_carry;
            r_count  <= r_count - w_n;
        end
    end

endmodule
`default_nettype wire
